// File: rtl/rr_priority_arbiter.sv
// Hold-until-release arbiter with fixed-priority or round-robin selection.
// Define ARB_TIMEOUT_EN to add a grant watchdog; "release" is reserved, so the free strobe is grant_release.
module rr_priority_arbiter #(
    parameter int unsigned PORTS        = 4,
    parameter string       TYPE         = "PRIORITY",
    parameter string       LSB_PRIORITY = "LOW",
    parameter int unsigned TIMEOUT      = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PORTS-1:0]         request,
    input  logic                     grant_release,
    output logic                     grant_valid,
    output logic [PORTS-1:0]         grant,
    output logic [$clog2(PORTS)-1:0] grant_encoded,
    output logic                     timeout
);
    localparam int unsigned      IDX_W       = $clog2(PORTS);
    localparam bit               IS_RR       = (TYPE == "ROUND_ROBIN");
    localparam bit               SCAN_UP     = (LSB_PRIORITY == "HIGH");
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(PORTS - 1);
    localparam logic [IDX_W-1:0] FIXED_START = SCAN_UP ? '0 : LAST_IDX;

    if (PORTS < 2 || PORTS > 64 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_cfg
        $error("rr_priority_arbiter: PORTS or TIMEOUT out of range");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             state, state_d;
    logic [PORTS-1:0]   grant_d;
    logic [IDX_W-1:0]   enc_d;
    logic [IDX_W-1:0]   rr_start, rr_d;
    logic [IDX_W-1:0]   scan_start;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic               load;
    logic               free;
    logic               wd_expire;
    int unsigned        pos;

    assign scan_start = IS_RR ? rr_start : FIXED_START;
    assign free       = grant_release | wd_expire;

    // First requester found scanning from scan_start in the configured direction, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        pos       = 0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            pos = SCAN_UP ? (32'(scan_start) + i) % PORTS
                          : (32'(scan_start) + PORTS - i) % PORTS;
            if (!win_found && request[IDX_W'(pos)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(pos);
            end
        end
    end

    // Next state, next grant and round-robin start point.
    always_comb begin
        state_d = state;
        grant_d = grant;
        enc_d   = grant_encoded;
        rr_d    = rr_start;
        load    = 1'b0;
        case (state)
            S_IDLE: load = win_found;
            S_GRANT: begin
                if (free) begin
                    if (win_found) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = '0;
                        enc_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            state_d = S_GRANT;
            grant_d = PORTS'(1) << win_idx;
            enc_d   = win_idx;
            if (SCAN_UP) begin
                rr_d = (win_idx == LAST_IDX) ? '0 : IDX_W'(win_idx + 1'b1);
            end else begin
                rr_d = (win_idx == '0) ? LAST_IDX : IDX_W'(win_idx - 1'b1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            grant_valid   <= 1'b0;
            grant         <= '0;
            grant_encoded <= '0;
            rr_start      <= FIXED_START;
        end else begin
            state         <= state_d;
            grant_valid   <= (state_d == S_GRANT);
            grant         <= grant_d;
            grant_encoded <= enc_d;
            rr_start      <= rr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    logic [15:0] wd_cnt, wd_cnt_d;
    logic        timeout_d;

    assign wd_expire = (state == S_GRANT) && (wd_cnt == WD_LAST);

    // Cycles spent holding the current grant; restarts on every load.
    always_comb begin
        wd_cnt_d  = wd_cnt + 16'd1;
        timeout_d = wd_expire && !grant_release;
        if (load || state_d == S_IDLE) begin
            wd_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            wd_cnt  <= wd_cnt_d;
            timeout <= timeout_d;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench for rr_priority_arbiter: fixed priority, round robin, 5-port, reset and watchdog.
module tb_rr_priority_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4-port fixed priority, highest index wins, watchdog limit 8
    logic [3:0] p_req = '0;
    logic       p_rel = 1'b0;
    logic       p_valid, p_to;
    logic [3:0] p_grant;
    logic [1:0] p_enc;

    // 4-port round robin, scanning upward
    logic [3:0] r_req = '0;
    logic       r_rel = 1'b0;
    logic       r_valid, r_to;
    logic [3:0] r_grant;
    logic [1:0] r_enc;

    // 5-port fixed priority, index 0 wins
    logic [4:0] f_req = '0;
    logic       f_rel = 1'b0;
    logic       f_valid, f_to;
    logic [4:0] f_grant;
    logic [2:0] f_enc;

    int n_checks = 0;
    int n_fail   = 0;

    rr_priority_arbiter #(.PORTS(4), .TYPE("PRIORITY"), .LSB_PRIORITY("LOW"), .TIMEOUT(8)) u_pri (
        .clk(clk), .rst_n(rst_n), .request(p_req), .grant_release(p_rel),
        .grant_valid(p_valid), .grant(p_grant), .grant_encoded(p_enc), .timeout(p_to)
    );

    rr_priority_arbiter #(.PORTS(4), .TYPE("ROUND_ROBIN"), .LSB_PRIORITY("HIGH"), .TIMEOUT(256)) u_rr (
        .clk(clk), .rst_n(rst_n), .request(r_req), .grant_release(r_rel),
        .grant_valid(r_valid), .grant(r_grant), .grant_encoded(r_enc), .timeout(r_to)
    );

    rr_priority_arbiter #(.PORTS(5), .TYPE("PRIORITY"), .LSB_PRIORITY("HIGH"), .TIMEOUT(256)) u_p5 (
        .clk(clk), .rst_n(rst_n), .request(f_req), .grant_release(f_rel),
        .grant_valid(f_valid), .grant(f_grant), .grant_encoded(f_enc), .timeout(f_to)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rr_exp[5];
        rr_exp = '{0, 1, 3, 0, 1};

        // reset state
        tick();
        tick();
        check("rst_p_valid", 32'(p_valid), 0);
        check("rst_p_grant", 32'(p_grant), 0);
        check("rst_p_enc",   32'(p_enc),   0);
        check("rst_p_to",    32'(p_to),    0);
        check("rst_r_valid", 32'(r_valid), 0);
        check("rst_f_grant", 32'(f_grant), 0);
        rst_n = 1'b1;

        // fixed priority, highest index wins
        p_req = 4'b0101;
        tick();
        check("pri_grant", 32'(p_grant), 32'h4);
        check("pri_enc",   32'(p_enc),   2);
        check("pri_valid", 32'(p_valid), 1);
        p_req = 4'b1111;
        tick();
        check("pri_hold_enc", 32'(p_enc), 2);
        p_rel = 1'b1;
        p_req = 4'b0011;
        tick();
        check("pri_b2b_grant", 32'(p_grant), 32'h2);
        check("pri_b2b_valid", 32'(p_valid), 1);
        p_req = 4'b0000;
        tick();
        check("pri_idle_valid", 32'(p_valid), 0);
        check("pri_idle_grant", 32'(p_grant), 0);
        tick();
        check("pri_rel_in_idle", 32'(p_valid), 0);
        p_rel = 1'b0;

        // round robin with release pulsed every cycle
        r_req = 4'b1011;
        r_rel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rr_seq%0d", i), 32'(r_enc), 32'(rr_exp[i]));
        end
        check("rr_seq_valid", 32'(r_valid), 1);
        r_req = 4'b0010;
        tick();
        check("rr_sole_holder", 32'(r_enc), 1);
        r_req = 4'b0100;
        tick();
        check("rr_next_grant", 32'(r_grant), 32'h4);
        r_rel = 1'b0;
        tick();
        check("rr_hold_enc", 32'(r_enc), 2);

        // asynchronous reset mid-grant
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(r_valid), 0);
        check("arst_grant", 32'(r_grant), 0);
        check("arst_enc",   32'(r_enc),   0);
        check("arst_to",    32'(r_to),    0);
        tick();
        rst_n = 1'b1;
        r_req = 4'b1100;
        tick();
        check("rr_post_rst_enc",   32'(r_enc),   2);
        check("rr_post_rst_valid", 32'(r_valid), 1);
        r_req = 4'b0000;
        r_rel = 1'b1;
        tick();
        check("rr_post_rst_idle", 32'(r_valid), 0);
        r_rel = 1'b0;

        // 5-port, index 0 wins, holder drops request
        f_req = 5'b10000;
        tick();
        check("p5_grant", 32'(f_grant), 32'h10);
        check("p5_enc",   32'(f_enc),   4);
        f_req = 5'b00000;
        tick();
        tick();
        tick();
        check("p5_held_grant", 32'(f_grant), 32'h10);
        check("p5_held_valid", 32'(f_valid), 1);
        f_rel = 1'b1;
        tick();
        check("p5_idle_valid", 32'(f_valid), 0);
        check("p5_idle_grant", 32'(f_grant), 0);
        f_req = 5'b10110;
        tick();
        check("p5_low_wins_grant", 32'(f_grant), 32'h2);
        check("p5_low_wins_enc",   32'(f_enc),   1);
        f_req = 5'b00000;
        tick();
        f_rel = 1'b0;

        // grant watchdog
        p_req = 4'b0010;
        tick();
        check("wd_load_enc", 32'(p_enc), 1);
        p_req = 4'b0000;
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("wd_hold_valid%0d", i), 32'(p_valid), 1);
            check($sformatf("wd_hold_to%0d", i),    32'(p_to),    0);
        end
`ifdef ARB_TIMEOUT_EN
        tick();
        check("wd_expire_valid", 32'(p_valid), 0);
        check("wd_expire_to",    32'(p_to),    1);
        tick();
        check("wd_pulse_end", 32'(p_to), 0);
`else
        for (int i = 8; i < 100; i++) begin
            tick();
            check($sformatf("nowd_valid%0d", i), 32'(p_valid), 1);
            check($sformatf("nowd_to%0d", i),    32'(p_to),    0);
        end
        check("nowd_enc", 32'(p_enc), 1);
        p_rel = 1'b1;
        tick();
        check("nowd_release", 32'(p_valid), 0);
        p_rel = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_priority_arbiter.md
RR_PRIORITY_ARBITER -- requirements
Module: rr_priority_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 4: number of requesters; legal range 2..64; non-power-of-two values supported.
REQ-002 SHALL have parameter TYPE, default "PRIORITY": arbitration mode, "PRIORITY" (fixed) or "ROUND_ROBIN".
REQ-003 SHALL have parameter LSB_PRIORITY, default "LOW": "LOW" means the highest index wins; "HIGH" means index 0 wins.
REQ-004 SHALL have parameter TIMEOUT, default 256: grant watchdog limit in cycles, legal range 2..65535, used only under ARB_TIMEOUT_EN.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port request, input, PORTS bits: one request bit per requester, level-sensitive.
REQ-008 SHALL have port release, input, 1 bit: holder frees the current grant.
REQ-009 SHALL have port grant_valid, output, 1 bit: a grant is held.
REQ-010 SHALL have port grant, output, PORTS bits: one-hot grant, all zero when grant_valid=0.
REQ-011 SHALL have port grant_encoded, output, $clog2(PORTS) bits: binary index of the granted port, 0 when idle.
REQ-012 SHALL have port timeout, output, 1 bit: one-cycle pulse when the watchdog forces a release.

Function
REQ-013 SHALL implement two states, IDLE and GRANT; grant_valid=1 exactly when the state is GRANT.
REQ-014 IDLE with |request=1 at an edge: SHALL load the winner into grant and grant_encoded and enter GRANT, so the grant is visible one cycle after the request.
REQ-015 IDLE with request=0: SHALL remain in IDLE with all outputs zero.
REQ-016 In GRANT, grant and grant_encoded SHALL stay stable regardless of request changes, including deassertion by the holder, until release or timeout.
REQ-017 GRANT with release=1 and no request bit set: SHALL return to IDLE at the next edge.
REQ-018 GRANT with release=1 and some request bit set: SHALL arbitrate at the same edge and load the new winner (back-to-back, no idle cycle); grant_valid stays 1.
REQ-019 release=1 in IDLE SHALL be ignored.
REQ-020 PRIORITY mode: the winner SHALL be the highest set index (LSB_PRIORITY="LOW") or the lowest set index ("HIGH"); the holder may win again.
REQ-021 ROUND_ROBIN mode, after granting index k: the next winner SHALL be the first requesting port scanning from k+1 upward, wrapping ("HIGH"), or from k-1 downward, wrapping ("LOW").
REQ-022 ROUND_ROBIN mode: k itself SHALL win only when it is the sole requester.
REQ-023 ROUND_ROBIN pointer SHALL update only on a new grant load.
REQ-024 Selection logic SHALL be an iterative loop over PORTS; module recursion is not permitted.
REQ-025 Ports at index >= PORTS SHALL not exist; no padding is exposed.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, grant_valid=0, grant=0, grant_encoded=0 and timeout=0, clear the watchdog counter, and reset the round-robin pointer so the first grant follows fixed-priority order.
REQ-027 Reset asserted mid-grant SHALL drop the grant without a timeout pulse.
REQ-028 After rst_n deasserts, the first arbitration SHALL occur at the first rising edge with rst_n=1.

Configuration
REQ-029 Macro ARB_TIMEOUT_EN defined: a counter SHALL count cycles in GRANT and clear on every grant load.
REQ-030 Macro ARB_TIMEOUT_EN defined: when the counter reaches TIMEOUT-1 with release=0, the block SHALL act as if release=1 and pulse timeout for one cycle, coincident with the edge where the grant is freed.
REQ-031 Macro ARB_TIMEOUT_EN not defined: there SHALL be no counter, timeout SHALL be constant 0, and a grant SHALL be held indefinitely.

Verification
REQ-032 PORTS=4, PRIORITY, "LOW": request=4'b0101 -> next cycle grant=4'b0100, grant_encoded=2, grant_valid=1.
REQ-033 PORTS=4, ROUND_ROBIN, "HIGH": request held at 4'b1011, release pulsed each cycle -> grant_encoded sequence 0,1,3,0,1.
REQ-034 PORTS=5, PRIORITY, "HIGH": request=5'b10000, holder drops request while release stays 0 -> grant=5'b10000 held; then release=1 with request=0 -> IDLE next cycle.
REQ-035 PORTS=4, ROUND_ROBIN: rst_n=0 asserted mid-grant -> outputs zero without waiting for clk; timeout=0; next grant follows fixed-priority order.
REQ-036 ARB_TIMEOUT_EN defined, TIMEOUT=8: request=4'b0010, release=0 -> grant freed after 8 grant cycles with a one-cycle timeout=1 pulse.
REQ-037 ARB_TIMEOUT_EN not defined, same stimulus as REQ-036 -> grant held for 100 cycles and timeout stays 0.
